psqwg_sequencer: RTL and testbench
==================================

Name: psqwg_sequencer

Overview:
Programmable square-wave pattern sequencer. A small on-chip table holds up to DEPTH segments. Each segment stores an on-time m, an off-time n and a repeat count rep. On start, the block plays the segments in order, driving sq_wave with per-segment duty, and either stops or loops after the last segment. It is the control layer above the basic programmable square-wave generator. Software or a higher-level FSM loads the table, then triggers a pattern.

Parameters:
DEPTH, 4, number of table entries (power of two, >=2)
IDX_W, 2, index width = log2(DEPTH)
TICK_DIV, 5, clocks per time unit for m and n (5 = 100 ns at 50 MHz)
REP_W, 4, width of the per-segment repeat count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  table write strobe
wr_addr  in  IDX_W  table entry to write
wr_m  in  4  on-time in units (0..15)
wr_n  in  4  off-time in units (0..15)
wr_rep  in  REP_W  repeat count; segment plays rep+1 periods
start  in  1  begin playback at entry 0 (level sampled each clock)
stop  in  1  abort playback
loop  in  1  1 = restart at entry 0 after last_idx
last_idx  in  IDX_W  index of the final segment in the pattern
sq_wave  out  1  registered square-wave output
busy  out  1  1 whenever state != IDLE
seg_idx  out  IDX_W  index of the segment currently playing
seg_tick  out  1  1-cycle pulse on the last cycle of each segment
done  out  1  1-cycle pulse when playback ends without loop

Behaviour:
- Reset: state IDLE; all table entries = 0; sq_wave=0, busy=0, seg_idx=0, seg_tick=0, done=0; all counters = 0.
- Table write: on wr_en, entry[wr_addr] <= {wr_m, wr_n, wr_rep} at that edge. Writes are legal in any state. The working copy of a segment is latched only in LOAD, so a write to the playing entry takes effect at that entry's next LOAD.
- States:
  - IDLE: start=1 and stop=0 -> LOAD with seg_idx=0.
  - LOAD: one cycle. Latch entry[seg_idx] into working m, n and rep counters.
    - m>0 -> HIGH.
    - m=0, n>0 -> LOW.
    - m=0, n=0 -> zero-length segment: seg_tick=1 in this cycle and advance (see segment end).
  - HIGH: lasts exactly m*TICK_DIV cycles. Then LOW if n>0; else the period ends.
  - LOW: lasts exactly n*TICK_DIV cycles. Then the period ends.
  - Period end: if the period counter < rep, increment it and go to HIGH (or LOW if m=0) with no gap cycle. Otherwise the segment ends.
  - Segment end: seg_tick=1 on the segment's final cycle (last LOW cycle, or last HIGH cycle if n=0, or the LOAD cycle if m=n=0).
    - If seg_idx != last_idx: seg_idx+1 (wraps DEPTH-1 -> 0), go to LOAD.
    - If seg_idx == last_idx and loop=1: seg_idx=0, go to LOAD.
    - If seg_idx == last_idx and loop=0: go to IDLE, done=1 in the first IDLE cycle.
  - loop and last_idx are sampled live at each segment end.
- sq_wave is a registered output: 1 exactly in HIGH cycles, 0 in IDLE, LOAD and LOW.
- Timing: start sampled at edge E0 gives LOAD during cycle E0..E1. sq_wave first rises after edge E1. Each segment starts with one LOAD cycle where sq_wave=0.
- Timing uses a unit prescaler (0..TICK_DIV-1) plus a 4-bit unit counter. There is no multiply in the datapath. Counters reset on every state change.
- stop=1: next state IDLE from any state. sq_wave=0 and seg_idx=0 next cycle; no done and no seg_tick. stop overrides start in the same cycle.
- start while busy is ignored.
- rst mid-playback: full reset as above, including table contents.

Test Plan:
1. TICK_DIV=5; entry0={m=2,n=1,rep=0}; last_idx=0, loop=0; pulse start -> 1 LOAD cycle, sq_wave high 10 clk, low 5 clk; seg_tick on the 15th; done 1 clk later; busy drops with done.
2. Entry0={1,1,2} -> after LOAD, three periods of 5 high / 5 low with no gap; exactly one seg_tick at the end of the third period.
3. Entries {3,0,0},{0,2,0},{0,0,0},{1,1,0}; last_idx=3 -> 15 high, LOAD, 10 low, LOAD with seg_tick (zero segment), LOAD, 5 high / 5 low; seg_idx steps 0,1,2,3; four seg_ticks; done once.
4. loop=1, last_idx=1 -> seg_idx sequence 0,1,0,1...; no done. Drop loop during segment 1 -> done at the end of that segment.
5. stop asserted mid-HIGH -> next cycle IDLE, sq_wave=0, seg_idx=0, no done. start+stop together in IDLE -> stays IDLE.
6. Rewrite entry0 while it plays (loop=1) -> current pass unchanged; the new m/n are visible after the next LOAD of entry 0. rst mid-play -> all outputs 0 next cycle, table zeroed.

Source files
------------

// File: rtl/psqwg_sequencer_if.sv
// Bus bundle for the square-wave pattern sequencer: table write port,
// playback control and playback status.
interface psqwg_sequencer_if #(
  parameter int IDX_W = 2,
  parameter int REP_W = 4
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3:0]       wr_m;
  logic [3:0]       wr_n;
  logic [REP_W-1:0] wr_rep;
  logic             start;
  logic             stop;
  logic             loop;
  logic [IDX_W-1:0] last_idx;
  logic             sq_wave;
  logic             busy;
  logic [IDX_W-1:0] seg_idx;
  logic             seg_tick;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_m, wr_n, wr_rep, start, stop, loop, last_idx,
    input  sq_wave, busy, seg_idx, seg_tick, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_m, wr_n, wr_rep, start, stop, loop, last_idx,
    output sq_wave, busy, seg_idx, seg_tick, done
  );
endinterface

// File: rtl/psqwg_sequencer.sv
// Square-wave pattern sequencer: plays a table of {on, off, repeat} segments,
// using a unit prescaler and a unit counter for timing.
module psqwg_sequencer #(
  parameter int DEPTH    = 4,
  parameter int IDX_W    = 2,
  parameter int TICK_DIV = 5,
  parameter int REP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  psqwg_sequencer_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HIGH, LOW} state_t;

  logic [3:0]       tab_m   [DEPTH];
  logic [3:0]       tab_n   [DEPTH];
  logic [REP_W-1:0] tab_rep [DEPTH];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [3:0]       m_reg, m_next;
  logic [3:0]       n_reg, n_next;
  logic [REP_W-1:0] rep_reg, rep_next;
  logic [REP_W-1:0] per_reg, per_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [3:0]       unit_reg, unit_next;
  logic             sq_reg;
  logic             done_reg, done_next;
  logic             seg_end, period_end, phase_end, seg_tick;
  logic [3:0]       phase_len;

  // Table is kept in registers because reset must clear every entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
      always_ff @(posedge clk) begin
        if (rst) begin
          tab_m[gi]   <= '0;
          tab_n[gi]   <= '0;
          tab_rep[gi] <= '0;
        end else if (bus.wr_en && bus.wr_addr == IDX_W'(gi)) begin
          tab_m[gi]   <= bus.wr_m;
          tab_n[gi]   <= bus.wr_n;
          tab_rep[gi] <= bus.wr_rep;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
      rep_reg   <= '0;
      per_reg   <= '0;
      pre_reg   <= '0;
      unit_reg  <= '0;
      sq_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      m_reg     <= m_next;
      n_reg     <= n_next;
      rep_reg   <= rep_next;
      per_reg   <= per_next;
      pre_reg   <= pre_next;
      unit_reg  <= unit_next;
      sq_reg    <= (state_next == HIGH);
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    m_next     = m_reg;
    n_next     = n_reg;
    rep_next   = rep_reg;
    per_next   = per_reg;
    pre_next   = '0;
    unit_next  = '0;
    done_next  = 1'b0;
    seg_end    = 1'b0;
    period_end = 1'b0;
    phase_len  = (state_reg == HIGH) ? m_reg : n_reg;
    phase_end  = (pre_reg == PRE_LAST) && (unit_reg == phase_len - 4'd1);

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        m_next   = tab_m[idx_reg];
        n_next   = tab_n[idx_reg];
        rep_next = tab_rep[idx_reg];
        per_next = '0;
        if (tab_m[idx_reg] != 4'd0)      state_next = HIGH;
        else if (tab_n[idx_reg] != 4'd0) state_next = LOW;
        else                             seg_end    = 1'b1;
      end
      HIGH, LOW: begin
        if (phase_end) begin
          if (state_reg == HIGH && n_reg != 4'd0) state_next = LOW;
          else                                    period_end = 1'b1;
        end else if (pre_reg == PRE_LAST) begin
          unit_next = unit_reg + 4'd1;
        end else begin
          pre_next  = pre_reg + 1'b1;
          unit_next = unit_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    // Repeat periods restart with no gap; counters are already cleared above.
    if (period_end) begin
      if (per_reg < rep_reg) begin
        per_next   = per_reg + 1'b1;
        state_next = (m_reg != 4'd0) ? HIGH : LOW;
      end else begin
        seg_end = 1'b1;
      end
    end

    if (seg_end) begin
      if (idx_reg != bus.last_idx) begin
        idx_next   = idx_reg + 1'b1;
        state_next = LOAD;
      end else if (bus.loop) begin
        idx_next   = '0;
        state_next = LOAD;
      end else begin
        idx_next   = '0;
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end

    if (bus.stop) begin
      state_next = IDLE;
      idx_next   = '0;
      done_next  = 1'b0;
      pre_next   = '0;
      unit_next  = '0;
    end

    seg_tick = seg_end && !bus.stop;
  end

  assign bus.sq_wave  = sq_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.seg_idx  = idx_reg;
  assign bus.seg_tick = seg_tick;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_psqwg_sequencer.sv
// Bench for psqwg_sequencer: segment-timeline reference model checked every
// cycle, directed scenarios with literal timing expectations, then random play.
module tb_psqwg_sequencer;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int TD    = 5;
  localparam int REP_W = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psqwg_sequencer_if #(.IDX_W(IDX_W), .REP_W(REP_W)) bus ();

  psqwg_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TICK_DIV(TD), .REP_W(REP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a segment is LOAD then a timeline of len cycles where
  // sq_wave is high while (t mod period) < m*TD.
  int mk = M_IDLE;
  int m_idx = 0, m_hi = 0, m_lo = 0, m_len = 0, m_t = 0;
  bit m_done = 0, m_known = 1;
  int tm[DEPTH], tn[DEPTH], tr[DEPTH];
  bit chk_en = 0;

  function automatic bit m_final();
    if (mk == M_LOAD) return (tm[m_idx] == 0) && (tn[m_idx] == 0);
    if (mk == M_PLAY) return m_t == m_len - 1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit fin, nd, seg_done;
    if (rst) begin
      mk = M_IDLE; m_idx = 0; m_done = 0; m_known = 1;
      for (int i = 0; i < DEPTH; i++) begin tm[i] = 0; tn[i] = 0; tr[i] = 0; end
    end else begin
      fin = m_final();
      nd = 0;
      seg_done = 0;
      if (bus.stop) begin
        mk = M_IDLE; m_idx = 0; m_known = 1;
      end else if (mk == M_IDLE) begin
        if (bus.start) begin mk = M_LOAD; m_idx = 0; m_known = 1; end
      end else if (mk == M_LOAD) begin
        if (fin) seg_done = 1;
        else begin
          m_hi = tm[m_idx] * TD;
          m_lo = tn[m_idx] * TD;
          m_len = (tr[m_idx] + 1) * (m_hi + m_lo);
          m_t = 0;
          mk = M_PLAY;
        end
      end else begin
        if (fin) seg_done = 1;
        else m_t++;
      end
      if (seg_done) begin
        if (m_idx != int'(bus.last_idx)) begin m_idx = (m_idx + 1) % DEPTH; mk = M_LOAD; end
        else if (bus.loop) begin m_idx = 0; mk = M_LOAD; end
        else begin mk = M_IDLE; nd = 1; m_known = 0; end
      end
      m_done = nd;
      if (bus.wr_en) begin
        tm[bus.wr_addr] = int'(bus.wr_m);
        tn[bus.wr_addr] = int'(bus.wr_n);
        tr[bus.wr_addr] = int'(bus.wr_rep);
      end
    end
  end

  int cyc = 0, hi_cnt = 0, exp_hi_cnt = 0, tick_cnt = 0, done_cnt = 0;
  int first_busy = -1, tick_at = -1, done_at = -1, tick_idx = -1;
  bit prev_busy = 0;

  always @(negedge clk) begin
    bit exp_sq;
    exp_sq = (mk == M_PLAY) && ((m_t % (m_hi + m_lo)) < m_hi);
    if (chk_en) begin
      chk("sq_wave", int'(bus.sq_wave), int'(exp_sq));
      chk("busy", int'(bus.busy), int'(mk != M_IDLE));
      chk("seg_tick", int'(bus.seg_tick), int'(m_final() && !bus.stop));
      chk("done", int'(bus.done), int'(m_done));
      if (m_known) chk("seg_idx", int'(bus.seg_idx), m_idx);
    end
    cyc++;
    if (bus.sq_wave) hi_cnt++;
    if (exp_sq) exp_hi_cnt++;
    if (bus.seg_tick) begin tick_cnt++; tick_at = cyc; tick_idx = int'(bus.seg_idx); end
    if (bus.done) begin done_cnt++; done_at = cyc; end
    if (bus.busy && !prev_busy && first_busy < 0) first_busy = cyc;
    prev_busy = bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    hi_cnt = 0; exp_hi_cnt = 0; tick_cnt = 0; done_cnt = 0;
    first_busy = -1; tick_at = -1; done_at = -1; tick_idx = -1;
  endtask

  task automatic wr(input int a, input int m, input int n, input int r);
    bus.wr_en = 1; bus.wr_addr = IDX_W'(a); bus.wr_m = 4'(m); bus.wr_n = 4'(n); bus.wr_rep = REP_W'(r);
    tick();
    bus.wr_en = 0;
  endtask

  task automatic run_start();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic wait_done(input int bound, input string name);
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_done_seen"}, int'(done_cnt > 0), 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_m = '0; bus.wr_n = '0; bus.wr_rep = '0;
    bus.start = 0; bus.stop = 0; bus.loop = 0; bus.last_idx = '0;
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst_sq_wave", int'(bus.sq_wave), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_seg_idx", int'(bus.seg_idx), 0);
    chk("rst_done", int'(bus.done), 0);

    // 1: single segment {2,1,0}
    wr(0, 2, 1, 0);
    clear_stats();
    run_start();
    wait_done(100, "t1");
    chk("t1_high_cycles", hi_cnt, 10);
    chk("t1_model_high_cycles", exp_hi_cnt, 10);
    chk("t1_ticks", tick_cnt, 1);
    chk("t1_tick_at", tick_at - first_busy, 15);
    chk("t1_done_at", done_at - first_busy, 16);

    // 2: repeated periods {1,1,2}
    wr(0, 1, 1, 2);
    clear_stats();
    run_start();
    wait_done(100, "t2");
    chk("t2_high_cycles", hi_cnt, 15);
    chk("t2_ticks", tick_cnt, 1);
    chk("t2_tick_at", tick_at - first_busy, 30);
    chk("t2_done_at", done_at - first_busy, 31);

    // 3: four segments including a zero-length one
    wr(0, 3, 0, 0); wr(1, 0, 2, 0); wr(2, 0, 0, 0); wr(3, 1, 1, 0);
    bus.last_idx = 2'd3;
    clear_stats();
    run_start();
    wait_done(200, "t3");
    chk("t3_high_cycles", hi_cnt, 20);
    chk("t3_ticks", tick_cnt, 4);
    chk("t3_dones", done_cnt, 1);
    chk("t3_last_tick_idx", tick_idx, 3);
    chk("t3_done_at", done_at - first_busy, 39);

    // 4: looping over entries 0..1, then drop loop during segment 1
    bus.last_idx = 2'd1; bus.loop = 1;
    clear_stats();
    run_start();
    repeat (100) tick();
    chk("t4_no_done_loop", done_cnt, 0);
    for (int i = 0; i < 100 && bus.seg_idx != 2'd1; i++) tick();
    chk("t4_reached_seg1", int'(bus.seg_idx), 1);
    bus.loop = 0;
    wait_done(100, "t4");
    chk("t4_end_idx", tick_idx, 1);
    chk("t4_dones", done_cnt, 1);

    // 5: stop mid-HIGH, then start+stop together
    bus.last_idx = 2'd0;
    clear_stats();
    run_start();
    repeat (5) tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("t5_stop_busy", int'(bus.busy), 0);
    chk("t5_stop_sq", int'(bus.sq_wave), 0);
    chk("t5_stop_idx", int'(bus.seg_idx), 0);
    repeat (5) tick();
    chk("t5_stop_no_done", done_cnt, 0);
    bus.start = 1; bus.stop = 1;
    tick();
    bus.start = 0; bus.stop = 0;
    chk("t5_start_stop_busy", int'(bus.busy), 0);

    // 6: rewrite the playing entry, then reset mid-play
    wr(0, 2, 0, 0);
    bus.loop = 1;
    clear_stats();
    run_start();
    repeat (4) tick();
    wr(0, 1, 1, 0);
    repeat (40) tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    chk("t6_high_cycles", hi_cnt, 26);
    chk("t6_no_done", done_cnt, 0);
    run_start();
    repeat (7) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_sq", int'(bus.sq_wave), 0);
    chk("t6_rst_idx", int'(bus.seg_idx), 0);
    bus.loop = 0; bus.last_idx = 2'd0;
    clear_stats();
    run_start();
    wait_done(20, "t6_zeroed");
    chk("t6_zero_high", hi_cnt, 0);
    chk("t6_zero_ticks", tick_cnt, 1);
    chk("t6_zero_done_at", done_at - first_busy, 1);

    // Random playback against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 800) == 0;
      bus.wr_en = ($urandom % 6) == 0;
      bus.wr_addr = IDX_W'($urandom % DEPTH);
      bus.wr_m = 4'($urandom % 4);
      bus.wr_n = 4'($urandom % 4);
      bus.wr_rep = REP_W'($urandom % 3);
      bus.start = ($urandom % 8) == 0;
      bus.stop = ($urandom % 50) == 0;
      if (($urandom % 40) == 0) bus.loop = 1'($urandom % 2);
      if (($urandom % 40) == 0) bus.last_idx = IDX_W'($urandom % DEPTH);
      tick();
    end
    rst = 0; bus.wr_en = 0; bus.start = 0; bus.stop = 1;
    tick();
    bus.stop = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
